// File: rtl/rom_scan_reader.sv
// Sequential reader for 556PT-family PROMs: manual single-word reads or full auto scans with
// ready/valid output. Optional running checksum enabled by ROM_SCAN_READER_CHECKSUM_EN.
module rom_scan_reader #(
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned ADDRESS_WIDTH = 9,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     auto_mode,
    input  logic                     start,
    input  logic                     increment_address,
    input  logic                     decrement_address,
    input  logic [DATA_WIDTH-1:0]    data_line_in,
    input  logic                     data_ready,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic                     data_valid,
    output logic                     busy,
    output logic                     scan_done,
    output logic [15:0]              checksum
);

    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StCapture,
        StHold,
        StAdvance
    } state_e;

    localparam logic [ADDRESS_WIDTH-1:0] AddrOne = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] AddrMax = '1;
    // The cycle in which the address changes is not counted as settled time.
    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES);

    state_e                   state_q, state_d;
    logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    data_q, data_d;
    logic [7:0]               settle_q, settle_d;
    logic                     auto_q, auto_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            data_q   <= '0;
            settle_q <= '0;
            auto_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            settle_q <= settle_d;
            auto_q   <= auto_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        data_d   = data_q;
        settle_d = settle_q;
        auto_d   = auto_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    auto_d   = auto_mode;
                    settle_d = '0;
                    state_d  = StSettle;
                    if (auto_mode) begin
                        addr_d = '0;
                    end
                end else if (increment_address && !decrement_address) begin
                    addr_d = addr_q + AddrOne;
                end else if (decrement_address && !increment_address) begin
                    addr_d = addr_q - AddrOne;
                end
            end
            StSettle: begin
                if (settle_q == SettleLast) begin
                    settle_d = '0;
                    state_d  = StCapture;
                end else begin
                    settle_d = settle_q + 8'd1;
                end
            end
            StCapture: begin
                data_d  = data_line_in;
                state_d = StHold;
            end
            StHold: begin
                if (data_ready) begin
                    state_d = auto_q ? StAdvance : StIdle;
                end
            end
            StAdvance: begin
                if (addr_q == AddrMax) begin
                    addr_d  = '0;
                    state_d = StIdle;
                end else begin
                    addr_d   = addr_q + AddrOne;
                    settle_d = '0;
                    state_d  = StSettle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign operation    = (state_q == StSettle || state_q == StCapture) ? 4'b1100 : 4'b0000;
    assign address_line = addr_q;
    assign data_out     = data_q;
    assign data_valid   = (state_q == StHold);
    assign busy         = (state_q != StIdle);
    assign scan_done    = (state_q == StAdvance) && (addr_q == AddrMax);

`ifdef ROM_SCAN_READER_CHECKSUM_EN
    logic [15:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if (state_q == StIdle && start) begin
            sum_q <= '0;
        end else if (state_q == StCapture) begin
            sum_q <= sum_q + 16'(data_line_in);
        end
    end

    assign checksum = sum_q;
`else
    assign checksum = 16'h0000;
`endif

endmodule
